// File: rtl/cavlc_pkg.sv
// rtl/cavlc_pkg.sv - shared constants, coefficient type and FSM states for the CAVLC block rebuilder
package cavlc_pkg;
    localparam int COEF_W = 15;
    localparam int BLK_N  = 16;

    typedef logic [COEF_W-1:0] coef_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } rebuild_state_t;
endpackage

// File: rtl/cavlc_coeff_rebuild.sv
// rtl/cavlc_coeff_rebuild.sv - rebuilds a 4x4 coefficient block from TotalCoeff/total_zeros and level/run pairs
// Optional consistency checker on err: CAVLC_REBUILD_CHECK_EN
module cavlc_coeff_rebuild
    import cavlc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              hdr_valid,
    output logic              hdr_ready,
    input  logic [4:0]        total_coeff,
    input  logic [3:0]        total_zeros,
    input  logic              coef_valid,
    output logic              coef_ready,
    input  logic [COEF_W-1:0] coef_level,
    input  logic [3:0]        coef_run,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [COEF_W-1:0] dout_00,
    output logic [COEF_W-1:0] dout_01,
    output logic [COEF_W-1:0] dout_02,
    output logic [COEF_W-1:0] dout_03,
    output logic [COEF_W-1:0] dout_10,
    output logic [COEF_W-1:0] dout_11,
    output logic [COEF_W-1:0] dout_12,
    output logic [COEF_W-1:0] dout_13,
    output logic [COEF_W-1:0] dout_20,
    output logic [COEF_W-1:0] dout_21,
    output logic [COEF_W-1:0] dout_22,
    output logic [COEF_W-1:0] dout_23,
    output logic [COEF_W-1:0] dout_30,
    output logic [COEF_W-1:0] dout_31,
    output logic [COEF_W-1:0] dout_32,
    output logic [COEF_W-1:0] dout_33,
    output logic              err
);

    rebuild_state_t state_q, state_d;

    logic [4:0] pos;
    logic [4:0] cnt;
    logic [3:0] zeros_left;
    logic       pos_uf;
    coef_t      blk [BLK_N];

    logic       hdr_fire, coef_fire;
    logic       final_lvl, wr_ok;
    logic [5:0] pos_init, pos_step;

    always_comb begin
        state_d    = state_q;
        hdr_ready  = 1'b0;
        coef_ready = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                hdr_ready = 1'b1;
                if (hdr_valid)
                    state_d = (total_coeff == 5'd0) ? DONE : RUN;
            end
            RUN: begin
                coef_ready = 1'b1;
                if (coef_valid && final_lvl)
                    state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign hdr_fire  = hdr_valid & hdr_ready;
    assign coef_fire = coef_valid & coef_ready;
    assign final_lvl = (cnt <= 5'd1);
    // Once pos has gone below zero it must never drift back into a valid slot.
    assign wr_ok     = !pos_uf && !pos[4];
    assign pos_init  = {1'b0, total_coeff} + {2'b0, total_zeros} - 6'd1;
    assign pos_step  = {1'b0, pos} - 6'd1 - {2'b0, coef_run};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pos        <= 5'd0;
            cnt        <= 5'd0;
            zeros_left <= 4'd0;
            pos_uf     <= 1'b0;
            for (int i = 0; i < BLK_N; i++)
                blk[i] <= '0;
        end else begin
            state_q <= state_d;
            if (hdr_fire) begin
                for (int i = 0; i < BLK_N; i++)
                    blk[i] <= '0;
                cnt        <= total_coeff;
                zeros_left <= total_zeros;
                pos        <= pos_init[4:0];
                pos_uf     <= pos_init[5];
            end
            if (coef_fire) begin
                if (wr_ok)
                    blk[pos[3:0]] <= coef_level;
                cnt <= cnt - 5'd1;
                if (!final_lvl) begin
                    pos        <= pos_step[4:0];
                    pos_uf     <= pos_uf | pos_step[5];
                    zeros_left <= (coef_run > zeros_left) ? 4'd0 : zeros_left - coef_run;
                end
            end
        end
    end

`ifdef CAVLC_REBUILD_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (hdr_fire)
            err_q <= ({1'b0, total_coeff} + {2'b0, total_zeros} > 6'd16) || (total_coeff > 5'd16);
        else if (coef_fire &&
                 ((!final_lvl && coef_run > zeros_left) || !wr_ok || coef_level == '0))
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign dout_00 = blk[0];
    assign dout_01 = blk[1];
    assign dout_02 = blk[2];
    assign dout_03 = blk[3];
    assign dout_10 = blk[4];
    assign dout_11 = blk[5];
    assign dout_12 = blk[6];
    assign dout_13 = blk[7];
    assign dout_20 = blk[8];
    assign dout_21 = blk[9];
    assign dout_22 = blk[10];
    assign dout_23 = blk[11];
    assign dout_30 = blk[12];
    assign dout_31 = blk[13];
    assign dout_32 = blk[14];
    assign dout_33 = blk[15];

endmodule

// File: tb/tb_cavlc_coeff_rebuild.sv
// tb/tb_cavlc_coeff_rebuild.sv - directed self-checking bench for cavlc_coeff_rebuild
module tb_cavlc_coeff_rebuild;

    logic        clk = 1'b0;
    logic        rst;
    logic        hdr_valid, hdr_ready;
    logic [4:0]  total_coeff;
    logic [3:0]  total_zeros;
    logic        coef_valid, coef_ready;
    logic [14:0] coef_level;
    logic [3:0]  coef_run;
    logic        out_valid, out_ready;
    logic        err;
    logic [14:0] d00, d01, d02, d03, d10, d11, d12, d13;
    logic [14:0] d20, d21, d22, d23, d30, d31, d32, d33;
    logic [14:0] dout_arr [16];
    logic [14:0] exp_blk  [16];
    logic        exp_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cavlc_coeff_rebuild dut (
        .clk(clk), .rst(rst),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
        .total_coeff(total_coeff), .total_zeros(total_zeros),
        .coef_valid(coef_valid), .coef_ready(coef_ready),
        .coef_level(coef_level), .coef_run(coef_run),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout_00(d00), .dout_01(d01), .dout_02(d02), .dout_03(d03),
        .dout_10(d10), .dout_11(d11), .dout_12(d12), .dout_13(d13),
        .dout_20(d20), .dout_21(d21), .dout_22(d22), .dout_23(d23),
        .dout_30(d30), .dout_31(d31), .dout_32(d32), .dout_33(d33),
        .err(err)
    );

    assign dout_arr[0]  = d00;
    assign dout_arr[1]  = d01;
    assign dout_arr[2]  = d02;
    assign dout_arr[3]  = d03;
    assign dout_arr[4]  = d10;
    assign dout_arr[5]  = d11;
    assign dout_arr[6]  = d12;
    assign dout_arr[7]  = d13;
    assign dout_arr[8]  = d20;
    assign dout_arr[9]  = d21;
    assign dout_arr[10] = d22;
    assign dout_arr[11] = d23;
    assign dout_arr[12] = d30;
    assign dout_arr[13] = d31;
    assign dout_arr[14] = d32;
    assign dout_arr[15] = d33;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_exp();
        for (int i = 0; i < 16; i++)
            exp_blk[i] = 15'h0;
    endtask

    task automatic check_blk(input string tag);
        for (int i = 0; i < 16; i++)
            check($sformatf("%s_pos%0d", tag, i), {17'h0, dout_arr[i]}, {17'h0, exp_blk[i]});
    endtask

    task automatic send_hdr(input logic [4:0] tc, input logic [3:0] tz);
        hdr_valid   = 1'b1;
        total_coeff = tc;
        total_zeros = tz;
        check("hdr_ready_idle", {31'h0, hdr_ready}, 32'd1);
        @(posedge clk); #1;
        hdr_valid = 1'b0;
    endtask

    task automatic send_coef(input logic [14:0] lvl, input logic [3:0] run);
        coef_valid = 1'b1;
        coef_level = lvl;
        coef_run   = run;
        check("coef_ready_run", {31'h0, coef_ready}, 32'd1);
        @(posedge clk); #1;
        coef_valid = 1'b0;
    endtask

    task automatic accept_blk(input string tag);
        check({tag, "_out_valid"}, {31'h0, out_valid}, 32'd1);
        check({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, {31'h0, out_valid}, 32'd0);
        check({tag, "_hdr_ready_back"}, {31'h0, hdr_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        hdr_valid = 1'b0; total_coeff = 5'd0; total_zeros = 4'd0;
        coef_valid = 1'b0; coef_level = 15'h0; coef_run = 4'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clr_exp();
        check("rst_hdr_ready", {31'h0, hdr_ready}, 32'd1);
        check("rst_coef_ready", {31'h0, coef_ready}, 32'd0);
        check("rst_out_valid", {31'h0, out_valid}, 32'd0);
        check("rst_err", {31'h0, err}, 32'd0);
        check_blk("rst");
        rst = 1'b0;
        exp_err = 1'b0;

        // tc=3 tz=2: levels land at 4, 2, 1
        send_hdr(5'd3, 4'd2);
        send_coef(15'h0005, 4'd1);
        send_coef(15'h7FFF, 4'd0);
        check("t1_no_early_valid", {31'h0, out_valid}, 32'd0);
        send_coef(15'h0002, 4'd9);
        clr_exp();
        exp_blk[4] = 15'h0005; exp_blk[2] = 15'h7FFF; exp_blk[1] = 15'h0002;
        check_blk("t1");
        accept_blk("t1");

        // tc=0: empty block at N+1
        send_hdr(5'd0, 4'd0);
        check("t2_out_valid_n1", {31'h0, out_valid}, 32'd1);
        check("t2_coef_ready", {31'h0, coef_ready}, 32'd0);
        clr_exp();
        check_blk("t2");
        accept_blk("t2");

        // tc=16 tz=0: levels 1..16 back-to-back from position 15 down
        send_hdr(5'd16, 4'd0);
        for (int k = 1; k <= 16; k++)
            send_coef(15'(k), 4'd0);
        clr_exp();
        for (int i = 0; i < 16; i++)
            exp_blk[i] = 15'(16 - i);
        check_blk("t3");

        // hold in DONE with a competing header
        for (int c = 0; c < 5; c++) begin
            hdr_valid = 1'b1; total_coeff = 5'd1; total_zeros = 4'd0;
            @(posedge clk); #1;
            check("t4_hold_valid", {31'h0, out_valid}, 32'd1);
            check("t4_hold_hdr_ready", {31'h0, hdr_ready}, 32'd0);
            check("t4_hold_d33", {17'h0, d33}, 32'd1);
            check("t4_hold_d00", {17'h0, d00}, 32'd16);
        end
        hdr_valid = 1'b0;
        check_blk("t4");
        accept_blk("t4");

        // reset after 2 of 4 pairs
        send_hdr(5'd4, 4'd0);
        send_coef(15'h0009, 4'd0);
        send_coef(15'h0008, 4'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clr_exp();
        check("t5_rst_hdr_ready", {31'h0, hdr_ready}, 32'd1);
        check("t5_rst_coef_ready", {31'h0, coef_ready}, 32'd0);
        check("t5_rst_out_valid", {31'h0, out_valid}, 32'd0);
        check_blk("t5_rst");
        send_hdr(5'd2, 4'd1);
        send_coef(15'h0003, 4'd1);
        send_coef(15'h7FFE, 4'd0);
        exp_blk[2] = 15'h0003; exp_blk[0] = 15'h7FFE;
        check_blk("t5");
        accept_blk("t5");

        // run exceeds zeros_left: pos underflows, later writes suppressed
        send_hdr(5'd3, 4'd1);
        send_coef(15'h0004, 4'd3);
        send_coef(15'h0005, 4'd0);
        send_coef(15'h0006, 4'd0);
        clr_exp();
        exp_blk[3] = 15'h0004;
`ifdef CAVLC_REBUILD_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        check_blk("t6");
        accept_blk("t6");

        // tc+tz>16: start position 17, first two writes out of range
        send_hdr(5'd10, 4'd8);
        check("t7_err_hdr", {31'h0, err}, {31'h0, exp_err});
        for (int k = 1; k <= 10; k++)
            send_coef(15'(k), 4'd0);
        clr_exp();
        for (int i = 8; i < 16; i++)
            exp_blk[i] = 15'(18 - i);
        check_blk("t7");
        accept_blk("t7");

        // err cleared by the next header
        exp_err = 1'b0;
        send_hdr(5'd1, 4'd0);
        check("t8_err_clear", {31'h0, err}, 32'd0);
        send_coef(15'h0001, 4'd0);
        clr_exp();
        exp_blk[0] = 15'h0001;
        check_blk("t8");
        accept_blk("t8");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
